lfsr_stream: RTL and testbench

Parametrised Fibonacci LFSR pseudo-random generator with a valid/ready output stream, handshaked seed loading, lock-up recovery and hardware period measurement. Next-generation replacement for the fixed 8/16-bit LFSR blocks: width, taps, start value and output width are parameters, and the generator only advances when a consumer accepts a word. It feeds the PRNG-driven stimulus and dither paths of the mixed-signal test fabric.

---
 rtl/lfsr_stream.sv | 116 +++++++++++
 tb/tb_lfsr_stream.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream.sv
// Parametrised Fibonacci LFSR word stream with seed handshake, lock-up recovery and period measurement.
// Zero latency (out_data is the state register); the state advances only on an accepted word and holds under backpressure.
module lfsr_stream #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] INIT  = 16'h0001,
  parameter int               OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [WIDTH-1:0] seed_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             wrap,
  output logic [WIDTH-1:0] period_len,
  output logic             lockup,
  output logic             seed_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] cnt_q;

  logic             seed_fire;
  logic             zero_st;
  logic             step;
  logic             fb;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH-1:0] seed_sel;
  logic [WIDTH-1:0] cnt_inc;
  logic             closes;

  // Datapath: next state, seed substitution, saturating step count.
  always_comb begin
    fb       = ^(s_q & TAPS);
    s_next   = {s_q[WIDTH-2:0], fb};
    seed_sel = (seed_data == '0) ? INIT : seed_data;
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  // Handshake decode and next FSM state; a zero state suppresses the step.
  always_comb begin
    state_d    = state_q;
    seed_ready = (state_q == IDLE);
    out_valid  = (state_q != IDLE);
    seed_fire  = seed_valid && seed_ready;
    zero_st    = out_valid && (s_q == '0);
    step       = out_valid && out_ready && !zero_st;
    closes     = step && (s_next == start_q);
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = step ? IDLE : DRAIN;
      DRAIN:   if (step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q        <= INIT;
      start_q    <= INIT;
      cnt_q      <= '0;
      period_len <= '0;
      wrap       <= 1'b0;
      lockup     <= 1'b0;
      seed_err   <= 1'b0;
    end else begin
      wrap   <= 1'b0;
      lockup <= 1'b0;
      if (seed_fire) begin
        s_q      <= seed_sel;
        start_q  <= seed_sel;
        cnt_q    <= '0;
        seed_err <= (seed_data == '0);
      end else if (zero_st) begin
        // Corrupted state: restart the sequence and its period measurement from INIT.
        s_q     <= INIT;
        start_q <= INIT;
        cnt_q   <= '0;
        lockup  <= 1'b1;
      end else if (step) begin
        s_q <= s_next;
        if (closes) begin
          wrap       <= 1'b1;
          period_len <= cnt_inc;
          cnt_q      <= '0;
        end else begin
          cnt_q <= cnt_inc;
        end
      end
    end
  end

  assign out_data = s_q[OUT_W-1:0];

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed/random bench for lfsr_stream against a parity-based arithmetic LFSR model.
module tb_lfsr_stream;

  localparam logic [31:0] TAPS16 = 32'h0000_B400;
  localparam logic [31:0] TAPS4  = 32'h0000_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        seed_valid;
  logic        seed_ready;
  logic [15:0] seed_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        wrap;
  logic [15:0] period_len;
  logic        lockup;
  logic        seed_err;

  logic        en4;
  logic        seed_ready4;
  logic        out_valid4;
  logic        out_ready4;
  logic [3:0]  out_data4;
  logic        wrap4;
  logic [3:0]  period_len4;
  logic        lockup4;
  logic        seed_err4;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_s;
  logic [31:0] m_start;
  int          m_cnt;
  int          m_plen;

  always #5 clk = ~clk;

  lfsr_stream dut (
    .clk(clk), .rst(rst), .en(en),
    .seed_valid(seed_valid), .seed_ready(seed_ready), .seed_data(seed_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .wrap(wrap), .period_len(period_len), .lockup(lockup), .seed_err(seed_err)
  );

  lfsr_stream #(.WIDTH(4), .TAPS(4'hC), .INIT(4'h1), .OUT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4),
    .seed_valid(1'b0), .seed_ready(seed_ready4), .seed_data(4'h0),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .wrap(wrap4), .period_len(period_len4), .lockup(lockup4), .seed_err(seed_err4)
  );

  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps, input int w);
    logic [31:0] mask;
    int          ones;
    mask = (32'd1 << w) - 32'd1;
    ones = $countones(s & taps);
    return ((s << 1) | 32'(ones % 2)) & mask;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_step(output bit w);
    m_s = lfsr_next(m_s, TAPS16, 16);
    m_cnt++;
    w = (m_s == m_start);
    if (w) begin
      m_plen = m_cnt;
      m_cnt  = 0;
    end
  endtask

  task automatic model_load(input logic [31:0] v);
    m_s     = v;
    m_start = v;
    m_cnt   = 0;
  endtask

  task automatic run_cycle(input bit rdy);
    bit w;
    out_ready = rdy;
    tick();
    w = 1'b0;
    if (rdy) model_step(w);
    chk("valid", 32'(out_valid), 32'd1);
    chk("data", 32'(out_data), m_s & 32'hFF);
    chk("wrap", 32'(wrap), 32'(w));
    if (w) chk("period_len", 32'(period_len), 32'(m_plen));
  endtask

  initial begin
    logic [7:0] first12 [12];
    bit         w;
    logic [31:0] m4;
    first12 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h00, 8'h00, 8'h01};

    rst = 1'b1; en = 1'b0; seed_valid = 1'b0; seed_data = '0; out_ready = 1'b0;
    en4 = 1'b0; out_ready4 = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_seed_ready", 32'(seed_ready), 32'd1);
    chk("rst_data", 32'(out_data), 32'h01);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_lockup", 32'(lockup), 32'd0);
    chk("rst_seed_err", 32'(seed_err), 32'd0);
    chk("rst_period_len", 32'(period_len), 32'd0);

    // Free run from INIT: full period of 65535 handshakes.
    rst = 1'b0; en = 1'b1; out_ready = 1'b1;
    tick();
    model_load(32'h1);
    chk("run_valid", 32'(out_valid), 32'd1);
    chk("first_word", 32'(out_data), 32'h01);
    for (int i = 0; i < 65535; i++) begin
      run_cycle(1'b1);
      if (i < 11) chk("first12", 32'(out_data), 32'(first12[i+1]));
      if (i == 10) chk("state_after_11", 32'(dut.s_q), 32'h0801);
    end
    chk("wrap_at_65535", 32'(wrap), 32'd1);
    chk("period_ffff", 32'(period_len), 32'hFFFF);
    chk("wrap_data", 32'(out_data), 32'h01);

    // Random backpressure: accepted sequence must continue the free-run sequence.
    for (int i = 0; i < 600; i++) run_cycle(1'($urandom_range(0, 1)));

    // Drop en while stalled: word held until one transfer completes.
    out_ready = 1'b0; en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_hold", 32'(out_data), m_s & 32'hFF);
      chk("drain_seed_ready", 32'(seed_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    model_step(w);
    chk("drain_done_valid", 32'(out_valid), 32'd0);
    chk("drain_done_seed_ready", 32'(seed_ready), 32'd1);
    chk("drain_done_data", 32'(out_data), m_s & 32'hFF);
    out_ready = 1'b0;

    // Seed ACE1 with en high.
    seed_valid = 1'b1; seed_data = 16'hACE1; en = 1'b1;
    tick();
    seed_valid = 1'b0;
    model_load(32'hACE1);
    chk("seed_valid_out", 32'(out_valid), 32'd1);
    chk("seed_word", 32'(out_data), 32'hE1);
    chk("seed_err_clear", 32'(seed_err), 32'd0);
    for (int i = 0; i < 3; i++) run_cycle(1'b1);
    en = 1'b0; out_ready = 1'b1;
    tick();
    model_step(w);
    chk("stop_direct_idle", 32'(out_valid), 32'd0);
    chk("stop_seed_ready", 32'(seed_ready), 32'd1);
    out_ready = 1'b0;

    // Zero seed substitutes INIT and flags seed_err.
    seed_valid = 1'b1; seed_data = 16'h0000; en = 1'b1;
    tick();
    seed_valid = 1'b0;
    model_load(32'h1);
    chk("zero_seed_word", 32'(out_data), 32'h01);
    chk("zero_seed_err", 32'(seed_err), 32'd1);
    for (int i = 0; i < 4; i++) run_cycle(1'b1);
    en = 1'b0; out_ready = 1'b1;
    tick();
    model_step(w);
    out_ready = 1'b0;
    chk("zero_seed_stop", 32'(out_valid), 32'd0);

    // Seed 0005 without en: stays idle, clears seed_err; en later starts the stream.
    seed_valid = 1'b1; seed_data = 16'h0005;
    tick();
    seed_valid = 1'b0;
    chk("seed5_err", 32'(seed_err), 32'd0);
    chk("seed5_idle", 32'(out_valid), 32'd0);
    chk("seed5_data", 32'(out_data), 32'h05);
    en = 1'b1;
    tick();
    model_load(32'h5);
    chk("en_rise_valid", 32'(out_valid), 32'd1);
    chk("en_rise_data", 32'(out_data), 32'h05);
    for (int i = 0; i < 3; i++) run_cycle(1'b1);

    // Corrupt the state to zero while stalled in RUN.
    out_ready = 1'b0;
    force dut.s_q = 16'h0000;
    #1;
    chk("forced_zero", 32'(out_data), 32'h00);
    release dut.s_q;
    tick();
    model_load(32'h1);
    chk("lockup_pulse", 32'(lockup), 32'd1);
    chk("lockup_data", 32'(out_data), 32'h01);
    chk("lockup_valid", 32'(out_valid), 32'd1);
    run_cycle(1'b0);
    chk("lockup_single", 32'(lockup), 32'd0);
    for (int i = 0; i < 3; i++) run_cycle(1'b1);

    // Asynchronous reset mid-stream.
    out_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_seed_ready", 32'(seed_ready), 32'd1);
    chk("arst_data", 32'(out_data), 32'h01);
    chk("arst_wrap", 32'(wrap), 32'd0);
    chk("arst_lockup", 32'(lockup), 32'd0);
    chk("arst_seed_err", 32'(seed_err), 32'd0);
    chk("arst_period_len", 32'(period_len), 32'd0);
    en = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // 4-bit instance: period 15.
    en4 = 1'b1; out_ready4 = 1'b1;
    tick();
    m4 = 32'h1;
    chk("w4_first", 32'(out_data4), 32'h1);
    for (int i = 0; i < 15; i++) begin
      tick();
      m4 = lfsr_next(m4, TAPS4, 4);
      chk("w4_data", 32'(out_data4), m4);
      chk("w4_wrap", 32'(wrap4), (i == 14) ? 32'd1 : 32'd0);
    end
    chk("w4_period", 32'(period_len4), 32'd15);
    chk("w4_back_to_1", 32'(out_data4), 32'h1);
    chk("w4_lockup", 32'(lockup4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
